// File: rtl/mult4_rr_sched.sv
// Round-robin scheduler sharing one 4x4 unsigned array multiplier among NREQ requesters,
// with an OUT_DEPTH result queue. Define MULT4_SCHED_PERF_EN to add the perf_ops counter.
module mult4_rr_sched #(
  parameter int NREQ      = 4,
  parameter int OUT_DEPTH = 2,
  localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [4*NREQ-1:0]   req_x,
  input  logic [4*NREQ-1:0]   req_y,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [7:0]          resp_p,
  output logic [IDW-1:0]      resp_id,
  output logic                busy
`ifdef MULT4_SCHED_PERF_EN
  ,output logic [15:0]        perf_ops
`endif
);

  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  function automatic logic [7:0] mul4_array(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc + ({4'b0000, a} << i);
    end
    return acc;
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [IDW-1:0] r_last;
  logic [CW-1:0]  r_count;
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [7:0]     r_q_p  [OUT_DEPTH];
  logic [IDW-1:0] r_q_id [OUT_DEPTH];

  logic           w_found_p0;
  logic [IDW-1:0] w_gidx_p0;
  logic [IDW-1:0] w_cand;
  logic [NREQ-1:0] w_gnt_p0;
  logic [3:0]     w_x_p0;
  logic [3:0]     w_y_p0;
  logic [7:0]     w_prod_p0;
  logic           w_pop;
  logic           w_space;
  logic           w_push;

  // Stage p0: round-robin search starting just after the last granted index
  always_comb begin
    w_found_p0 = 1'b0;
    w_gidx_p0  = '0;
    w_cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((int'(r_last) + k) % NREQ);
      if (!w_found_p0 && req_valid[w_cand]) begin
        w_found_p0 = 1'b1;
        w_gidx_p0  = w_cand;
      end
    end
  end

  always_comb begin
    w_gnt_p0 = '0;
    if (w_found_p0) w_gnt_p0[w_gidx_p0] = 1'b1;
  end

  assign w_x_p0    = req_x[{w_gidx_p0, 2'b00} +: 4];
  assign w_y_p0    = req_y[{w_gidx_p0, 2'b00} +: 4];
  assign w_prod_p0 = mul4_array(w_x_p0, w_y_p0);

  assign resp_valid = (r_count != '0);
  assign w_pop      = resp_valid & resp_ready;
  // A full queue still accepts when the head leaves in the same cycle
  assign w_space    = (r_count < CW'(OUT_DEPTH)) | w_pop;
  assign w_push     = w_found_p0 & w_space & ~rst;
  assign req_ready  = w_push ? w_gnt_p0 : '0;

  // Stage p1: result queue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last  <= IDW'(NREQ - 1);
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) begin
        r_last <= w_gidx_p0;
        r_wptr <= ptr_next(r_wptr);
      end
      if (w_pop) r_rptr <= ptr_next(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_p[r_wptr]  <= w_prod_p0;
      r_q_id[r_wptr] <= w_gidx_p0;
    end
  end

  assign resp_p  = resp_valid ? r_q_p[r_rptr]  : '0;
  assign resp_id = resp_valid ? r_q_id[r_rptr] : '0;
  assign busy    = (|req_valid) | resp_valid;

`ifdef MULT4_SCHED_PERF_EN
  logic [15:0] r_perf_ops;

  always_ff @(posedge clk) begin
    if (rst)         r_perf_ops <= '0;
    else if (w_push) r_perf_ops <= sat_inc16(r_perf_ops);
  end

  assign perf_ops = r_perf_ops;
`endif

endmodule

// File: tb/tb_mult4_rr_sched.sv
// Scoreboard bench for mult4_rr_sched: a cycle driver predicts grants from a round-robin
// model and queues expected products; a monitor compares the response port against that queue.
module tb_mult4_rr_sched;

  localparam int NREQ      = 4;
  localparam int OUT_DEPTH = 2;
  localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int XW        = 4 * NREQ;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [XW-1:0]   req_x = '0;
  logic [XW-1:0]   req_y = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [7:0]      resp_p;
  logic [IDW-1:0]  resp_id;
  logic            busy;
`ifdef MULT4_SCHED_PERF_EN
  logic [15:0]     perf_ops;
`endif

  mult4_rr_sched #(.NREQ(NREQ), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_p     (resp_p),
    .resp_id    (resp_id),
    .busy       (busy)
`ifdef MULT4_SCHED_PERF_EN
    ,.perf_ops  (perf_ops)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int sb[$];          // expected results in DUT order: (id << 8) | product
  int exp_cnt = 0;    // results the DUT should hold during the current cycle
  int last    = NREQ - 1;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; predicts the grant and records the expected result.
  task automatic cycle(input logic r, input logic [NREQ-1:0] v,
                       input logic [XW-1:0] xv, input logic [XW-1:0] yv, input logic rr);
    int gi;
    int xa;
    int yb;
    logic [NREQ-1:0] eg;
    @(negedge clk);
    rst = r; req_valid = v; req_x = xv; req_y = yv; resp_ready = rr;
    exp_cnt = sb.size();
    #1;
    gi = -1;
    if (!r && (exp_cnt < OUT_DEPTH || (exp_cnt > 0 && rr))) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (last + k) % NREQ;
        if (gi < 0 && ((int'(v) >> c) & 1) != 0) gi = c;
      end
    end
    eg = (gi >= 0) ? (NREQ'(1) << gi) : '0;
    if (chk_en || r) chk("req_ready", int'(req_ready), int'(eg));
    if (r) last = NREQ - 1;
    else if (gi >= 0) begin
      last = gi;
      xa = int'(xv >> (4 * gi)) & 15;
      yb = int'(yv >> (4 * gi)) & 15;
      sb.push_back((gi << 8) | (xa * yb));
    end
  endtask

  // Monitor: compares the response port with the scoreboard head every cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk_en && !rst) begin
        chk("resp_valid", int'(resp_valid), (exp_cnt > 0) ? 1 : 0);
        chk("busy", int'(busy), ((req_valid != '0) || exp_cnt > 0) ? 1 : 0);
        if (exp_cnt > 0 && sb.size() > 0) begin
          chk("resp_p", int'(resp_p), sb[0] & 255);
          chk("resp_id", int'(resp_id), sb[0] >> 8);
          if (resp_ready) void'(sb.pop_front());
        end else begin
          chk("resp_p_empty", int'(resp_p), 0);
          chk("resp_id_empty", int'(resp_id), 0);
        end
      end
      if (rst) begin
        sb.delete();
        chk_en = 1'b1;
      end
    end
  end

  initial begin
    logic [NREQ-1:0] rv;
    logic [XW-1:0]   rx;
    logic [XW-1:0]   ry;

    cycle(1'b1, '0, '0, '0, 1'b0);
    cycle(1'b1, '0, '0, '0, 1'b0);

    // First op after reset: 3*5 from requester 0
    cycle(1'b0, 4'b0001, 16'h0003, 16'h0005, 1'b1);
    cycle(1'b0, 4'b0000, '0, '0, 1'b1);

    // All requesting: grants rotate 0,1,2,3,0
    cycle(1'b1, '0, '0, '0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'b1111, XW'($urandom()), XW'($urandom()), 1'b1);
    cycle(1'b0, 4'b0000, '0, '0, 1'b1);
    cycle(1'b0, 4'b0000, '0, '0, 1'b1);

    // Back-pressure: 15*15 then 7*9 from requester 2 fill the queue
    cycle(1'b0, 4'b0100, 16'h0F00, 16'h0F00, 1'b0);
    cycle(1'b0, 4'b0100, 16'h0700, 16'h0900, 1'b0);
    cycle(1'b0, 4'b0100, 16'h0500, 16'h0500, 1'b0);
    cycle(1'b0, 4'b0100, 16'h0500, 16'h0500, 1'b0);
    // Full queue with a pop: push and pop together
    cycle(1'b0, 4'b0100, 16'h0200, 16'h0300, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0000, '0, '0, 1'b1);

    // Reset with two results held
    cycle(1'b0, 4'b0100, 16'h0F00, 16'h0E00, 1'b0);
    cycle(1'b0, 4'b1000, 16'hD000, 16'hC000, 1'b0);
    cycle(1'b1, 4'b0000, '0, '0, 1'b0);
    cycle(1'b0, 4'b1010, 16'h9090, 16'h8080, 1'b1);
    cycle(1'b0, 4'b0000, '0, '0, 1'b1);
    cycle(1'b0, 4'b0000, '0, '0, 1'b1);

    // Boundary operands
    cycle(1'b0, 4'b0001, 16'h000F, 16'h0000, 1'b1);
    cycle(1'b0, 4'b0010, 16'h00F0, 16'h00F0, 1'b1);
    cycle(1'b0, 4'b0000, '0, '0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      rv = NREQ'($urandom());
      rx = XW'($urandom());
      ry = XW'($urandom());
      cycle(($urandom() % 250) == 0, rv, rx, ry, ($urandom() % 4) != 0);
    end

    for (int i = 0; i < OUT_DEPTH + 3; i++) cycle(1'b0, '0, '0, '0, 1'b1);
    chk("drain", sb.size(), 0);

`ifdef MULT4_SCHED_PERF_EN
    cycle(1'b1, '0, '0, '0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 4'b0001, XW'($urandom()), XW'($urandom()), 1'b1);
    cycle(1'b0, '0, '0, '0, 1'b1);
    chk("perf_ops_10", int'(perf_ops), 10);
    force dut.r_perf_ops = 16'hFFFF;
    cycle(1'b0, '0, '0, '0, 1'b1);
    release dut.r_perf_ops;
    cycle(1'b0, 4'b0010, XW'($urandom()), XW'($urandom()), 1'b1);
    cycle(1'b0, '0, '0, '0, 1'b1);
    chk("perf_ops_sat", int'(perf_ops), 65535);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
